click_sync_sink: RTL
====================

# click_sync_sink

Clocked receive endpoint for a click-based 2-phase (transition-signalled) bundled-data pipeline. It takes the final stage's request toggle and bundled data, synchronises the request into `i_clk`, and captures the data into a small FIFO. It returns a 2-phase acknowledge toggle to the last click stage and presents the words to synchronous logic over a valid/ready interface.

## Interface
- `BW_DATA`, 8: width of the bundled data word.
- `FIFO_DEPTH`, 4: number of FIFO entries; must be a power of 2, ≥2.
- `SYNC_STAGES`, 2: number of request synchroniser flops; must be ≥2.
- `i_clk`  input  1  single clock; all state is updated on the rising edge.
- `i_rstn`  input  1  reset; synchronous, active-low.
- `i_req`  input  1  2-phase request from the last click stage (its `out_reqR`); asynchronous to `i_clk`.
- `i_data`  input  BW_DATA  bundled data; stable from an `i_req` transition until the matching `o_ack` transition.
- `o_ack`  output  1  2-phase acknowledge to the last click stage (its `in_ackR`); driven directly by a flop.
- `o_valid`  output  1  FIFO non-empty.
- `o_data`  output  BW_DATA  FIFO head word; valid only while `o_valid` = 1.
- `i_ready`  input  1  consumer accepts the head word.
- `o_count`  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `o_stall`  output  1  a transfer is pending but the FIFO is full.

## Operation
- **Synchroniser:** `i_req` passes through `SYNC_STAGES` flops, each with reset value 0. The last stage is `req_s`.
- **Pending:** `pending = req_s ^ ack_q`. `o_ack = ack_q`.
- **Control FSM:** two states.
  - S_IDLE: no transfer pending.
  - S_STALL: transfer pending and FIFO full.
- **Transitions:**
  - S_IDLE → S_STALL when `pending & full`.
  - S_STALL → S_IDLE after the capture edge.
- **Capture:** on any edge where `pending & ~full` holds (in either state):
  - write `i_data` into FIFO at `wr_ptr`;
  - `ack_q <= ~ack_q`;
  - exactly one capture per request transition.
- **Full:** `full` is evaluated from the registered count at the start of the cycle. A pop in the same cycle does not permit a push on a full FIFO; the push happens on the next edge.
- **Pop:** `o_valid & i_ready` advances `rd_ptr`.
  - `i_ready` while empty is ignored.
  - Simultaneous push and pop leaves `o_count` unchanged.
- **Pointers:** `$clog2(FIFO_DEPTH)+1` bits with an extra wrap bit.
  - Full when the MSBs differ and the remaining bits are equal.
  - Empty when the pointers are equal.
  - Pointers wrap modulo 2·FIFO_DEPTH.
- **Output read:** `o_data = mem[rd_ptr]`, combinational read of registered storage. No bypass from `i_data`.
- `o_stall = pending & full`.
- **Reset:** `ack_q`, the synchroniser flops, both pointers and the FSM clear to 0 / S_IDLE.
  - Outputs after reset: `o_ack`=0, `o_valid`=0, `o_count`=0, `o_stall`=0. `o_data` content is don't-care.
- **Reset mid-operation:** any pending transfer is dropped and FIFO contents are discarded.
  - The upstream click chain must be reset in the same interval. This is a system rule, not checked here.

## Timing
- **Request to capture:** an `i_req` toggle arriving before edge 1 is seen as `req_s` after edge `SYNC_STAGES`. The capture happens on edge `SYNC_STAGES+1`.
- **Visibility:** `o_ack` toggles and `o_valid` rises immediately after the capture edge.
- **Throughput:** at most one word per `SYNC_STAGES+1` cycles plus the upstream click forward latency.
- **Stall release:** from a full FIFO, a pop on edge k gives capture and `o_ack` toggle on edge k+1.
- **Data sampling:** `i_data` is sampled ≥`SYNC_STAGES` cycles after the `i_req` transition. The bundled-data constraint therefore guarantees settled data; `i_data` needs no synchroniser.

## Structure
- **Package `click_pkg`:**
  - FSM state enum `{S_IDLE, S_STALL}`;
  - default constants `CLICK_BW_DATA`=8, `CLICK_FIFO_DEPTH`=4, `CLICK_SYNC_STAGES`=2.
- **Sub-module `sync_fifo`:**
  - parameters `BW_DATA`, `FIFO_DEPTH`;
  - ports push/pop/din/dout/full/empty/count.
- The top level holds the synchroniser, `ack_q` and the FSM.

## Test plan
All cases use BW_DATA=8, FIFO_DEPTH=4, SYNC_STAGES=2.
- **Reset:** hold `i_rstn`=0 for 3 cycles with `i_req`=1 → `o_ack`=0, `o_valid`=0, `o_count`=0, `o_stall`=0 throughout. No capture occurs while in reset.
- **Single transfer:** `i_data`=0xA5, toggle `i_req` 0→1 before edge 1, `i_ready`=0.
  - After edge 3: `o_ack`=1, `o_valid`=1, `o_data`=0xA5, `o_count`=1.
  - Then `i_ready`=1 for one cycle → `o_valid`=0, `o_count`=0.
- **Fill and stall:** four handshakes with data 0x01–0x04 and `i_ready`=0 → `o_count`=4.
  - Fifth toggle with 0x05 → `o_ack` holds and `o_stall`=1.
  - Pop on edge k → `o_data`=0x02 after edge k; capture on edge k+1, `o_ack` toggles, `o_stall`=0, `o_count`=4.
- **Simultaneous push and pop:** at `o_count`=2 (0x10, 0x11), capture 0x12 on the same edge as a pop → `o_count`=2, `o_data`=0x11, then 0x12.
- **Reset mid-operation:** toggle `i_req` with 0x77 and assert `i_rstn`=0 after edge 2 → `o_ack` stays 0, `o_count`=0. After release with `i_req`=0 on both sides, no spurious capture occurs.
- **Wrap-around:** 10 handshakes with data 0x00–0x09 and `i_ready`=1 → 10 pops in order 0x00–0x09. `o_stall` is never asserted and `o_ack` toggles 10 times.

Source files
------------

// File: rtl/click_pkg.sv
// Shared types and default sizing for the click-to-synchronous receive endpoint.
package click_pkg;

    // Control FSM states: idle, or holding a pending transfer off a full FIFO
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_e;

    localparam int CLICK_BW_DATA     = 8;
    localparam int CLICK_FIFO_DEPTH  = 4;
    localparam int CLICK_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers, registered storage and a
// combinational read of the head entry.
module sync_fifo
    import click_pkg::*;
#(
    parameter int BW_DATA    = CLICK_BW_DATA,
    parameter int FIFO_DEPTH = CLICK_FIFO_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [BW_DATA-1:0]            i_din,
    output logic [BW_DATA-1:0]            o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      wrPtr_q, wrPtr_d;
    logic [PW-1:0]      rdPtr_q, rdPtr_d;
    logic [BW_DATA-1:0] mem_q [FIFO_DEPTH];
    logic               doPush;
    logic               doPop;

    // Full when the wrap bits differ but the index bits match; empty when equal
    assign o_full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign o_empty = (wrPtr_q == rdPtr_q);
    assign o_count = wrPtr_q - rdPtr_q;
    assign o_dout  = mem_q[rdPtr_q[AW-1:0]];

    assign doPush = i_push & ~o_full;
    assign doPop  = i_pop & ~o_empty;

    // Pointer advance; pointers wrap naturally modulo twice the depth
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
    end

    // Pointer registers with synchronous active-low clear
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: contents are only visible once a push has landed
    always_ff @(posedge i_clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/click_sync_sink.sv
// Receive endpoint for a 2-phase click pipeline: synchronises the request
// toggle, captures bundled data into a FIFO and answers with an ack toggle.
module click_sync_sink
    import click_pkg::*;
#(
    parameter int BW_DATA     = CLICK_BW_DATA,
    parameter int FIFO_DEPTH  = CLICK_FIFO_DEPTH,
    parameter int SYNC_STAGES = CLICK_SYNC_STAGES
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_req,
    input  logic [BW_DATA-1:0]            i_data,
    output logic                          o_ack,
    output logic                          o_valid,
    output logic [BW_DATA-1:0]            o_data,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_stall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    state_e                 state_q, state_d;
    logic                   reqSync;
    logic                   pending;
    logic                   capture;
    logic                   fifoFull;
    logic                   fifoEmpty;

    // A transfer is pending while the synchronised request differs from our ack.
    // Data is sampled several cycles after the request edge, so bundled-data
    // timing guarantees it has settled and it needs no synchroniser of its own.
    assign reqSync = sync_q[SYNC_STAGES-1];
    assign pending = reqSync ^ ack_q;
    assign capture = pending & ~fifoFull;
    assign o_ack   = ack_q;
    assign o_stall = pending & fifoFull;
    assign o_valid = ~fifoEmpty;

    // Shift chain next state and ack toggle on each capture
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_req};
        ack_d  = ack_q;
        if (capture) begin
            ack_d = ~ack_q;
        end
    end

    // Control FSM next state: stall while full, leave on the capture edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pending && fifoFull) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (capture) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Synchroniser, ack flop and FSM state with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync_q  <= '0;
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            sync_q  <= sync_d;
            ack_q   <= ack_d;
            state_q <= state_d;
        end
    end

    sync_fifo #(
        .BW_DATA    (BW_DATA),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (capture),
        .i_pop   (o_valid & i_ready),
        .i_din   (i_data),
        .o_dout  (o_data),
        .o_full  (fifoFull),
        .o_empty (fifoEmpty),
        .o_count (o_count)
    );

endmodule
